ps2_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4, 0xFF) to a keyboard/mouse.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_sync_edge.sv | 14 +
 rtl/ps2_tx.sv | 108 ++++++++++
 tb/tb_ps2_tx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, parity helper and default timing constants
package ps2_pkg;
  localparam int INHIBIT_CYCLES_DEF = 12_000;
  localparam int TIMEOUT_CYCLES_DEF = 2_000_000;
  typedef enum logic [3:0] {
    IDLE, INHIBIT, RTS, START, DATA, PARITY, STOP, ACKWAIT, DONE, ERR
  } tx_state_t;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 3-flop synchronizer for a PS/2 line with falling-edge detect, idles high
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic fall
);
  logic [2:0] sr;
  always_ff @(posedge clk)
    sr <= reset ? 3'b111 : {sr[1:0], din};
  assign sync = sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter driving open-drain ps2clk/ps2data
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int CW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  tx_state_t state;
  logic clk_low, data_low, par;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic clk_s, clk_fall, data_s, data_fall_unused;
  logic timed;
  assign ps2clk = clk_low ? 1'b0 : 1'bz;
  assign ps2data = data_low ? 1'b0 : 1'bz;
  ps2_sync_edge u_clk (.clk(clk), .reset(reset), .din(ps2clk), .sync(clk_s), .fall(clk_fall));
  ps2_sync_edge u_data (.clk(clk), .reset(reset), .din(ps2data), .sync(data_s), .fall(data_fall_unused));
  assign timed = state inside {START, DATA, PARITY, STOP, ACKWAIT};
  always_ff @(posedge clk) begin
    tx_done <= 1'b0;
    tx_err <= 1'b0;
    if (reset) begin
      state <= IDLE;
      clk_low <= 1'b0;
      data_low <= 1'b0;
      tx_busy <= 1'b0;
      par <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      cnt <= '0;
      tmo <= '0;
    end else begin
      tmo <= clk_fall ? '0 : tmo + 1'b1;
      case (state)
        IDLE: if (tx_start) begin
          state <= INHIBIT;
          clk_low <= 1'b1;
          cnt <= '0;
          shreg <= tx_data;
          par <= odd_parity(tx_data);
          bit_cnt <= '0;
          tx_busy <= 1'b1;
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            state <= RTS;
            data_low <= 1'b1;
          end
        end
        RTS: begin
          state <= START;
          clk_low <= 1'b0;
          tmo <= '0;
        end
        START: if (clk_fall) begin
          data_low <= ~shreg[0];
          shreg <= shreg >> 1;
          state <= DATA;
        end
        // bit_cnt counts the data bits still sent from DATA; at 7 the parity bit goes out
        DATA: if (clk_fall) begin
          data_low <= bit_cnt == 3'd7 ? ~par : ~shreg[0];
          shreg <= shreg >> 1;
          bit_cnt <= bit_cnt == 3'd7 ? bit_cnt : bit_cnt + 1'b1;
          state <= bit_cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: if (clk_fall) begin
          data_low <= 1'b0;
          state <= STOP;
        end
        STOP: if (clk_fall) begin
          state <= data_s ? ERR : ACKWAIT;
          tx_err <= data_s;
          tx_busy <= ~data_s;
        end
        ACKWAIT: if (clk_s && data_s) begin
          state <= DONE;
          tx_done <= 1'b1;
          tx_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (timed && !clk_fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= ERR;
        tx_err <= 1'b1;
        tx_done <= 1'b0;
        tx_busy <= 1'b0;
        clk_low <= 1'b0;
        data_low <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed vectors for ps2_tx with a simple PS/2 device model
module tb_ps2_tx;
  localparam int H = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_busy, tx_done, tx_err;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire ps2clk, ps2data;
  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;

  ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(5000)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .ps2clk(ps2clk), .ps2data(ps2data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int done_n = 0, err_n = 0, both_n = 0;
  always @(negedge clk) begin
    if (tx_done) done_n++;
    if (tx_err) err_n++;
    if (tx_done && tx_err) both_n++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int nclk,
                           output logic [9:0] seen, output bit ok);
    seen = '0;
    ok = 1'b0;
    @(negedge clk); tx_start = 1'b1; tx_data = d;
    @(negedge clk); tx_start = 1'b0; tx_data = ~d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (ps2clk === 1'b1 && ps2data === 1'b0);
    end
    if (!ok) return;
    for (int k = 1; k <= nclk; k++) begin
      dev_data_low = (k == 11) && ack;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      if (k <= 10) seen[k-1] = ps2data;
      if (k == 11) begin
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
    if (nclk == 11) begin
      for (int i = 0; i < 200 && tx_busy; i++) @(negedge clk);
      repeat (3) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ack;
    logic [7:0] exp_byte;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;
  vec_t v[5];

  initial begin
    logic [9:0] seen;
    bit ok;
    int d0, e0, lowcnt, n;
    logic last_data;
    v[0] = '{8'hF4, 1'b1, 8'hF4, 1'b0, 1, 0};
    v[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1, 0};
    v[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1, 0};
    v[3] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1, 0};
    v[4] = '{8'h01, 1'b0, 8'h01, 1'b0, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset outputs", {tx_busy, tx_done, tx_err}, 3'b000);
    chk("reset pins", {ps2clk, ps2data}, 2'b11);
    tx_start = 1'b1; tx_data = 8'hF4;
    @(negedge clk);
    tx_start = 1'b0;
    chk("reset beats start", {tx_busy, ps2clk}, 2'b01);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      d0 = done_n; e0 = err_n;
      run_frame(v[i].d, v[i].ack, 11, seen, ok);
      chk($sformatf("v%0d release", i), 32'(ok), 1);
      chk($sformatf("v%0d data bits", i), 32'(seen[7:0]), 32'(v[i].exp_byte));
      chk($sformatf("v%0d parity", i), 32'(seen[8]), 32'(v[i].exp_par));
      chk($sformatf("v%0d stop", i), 32'(seen[9]), 1);
      chk($sformatf("v%0d done pulses", i), 32'(done_n - d0), 32'(v[i].exp_done));
      chk($sformatf("v%0d err pulses", i), 32'(err_n - e0), 32'(v[i].exp_err));
      chk($sformatf("v%0d idle", i), {tx_busy, ps2clk, ps2data}, 3'b011);
    end

    // inhibit length, request-to-send ordering, then device silence -> timeout
    d0 = done_n; e0 = err_n;
    @(negedge clk); tx_start = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_start = 1'b0;
    chk("busy after accept", 32'(tx_busy), 1);
    lowcnt = 0;
    last_data = 1'b1;
    while (ps2clk === 1'b0 && lowcnt < 100) begin
      last_data = ps2data;
      lowcnt++;
      @(negedge clk);
    end
    chk("inhibit low cycles", 32'(lowcnt), 21);
    chk("data low before release", 32'(last_data), 0);
    n = 0;
    while (!tx_err && n < 6000) begin
      @(negedge clk);
      n++;
      tx_start = (n == 100);
    end
    tx_start = 1'b0;
    chk("timeout cycles", 32'(n), 5000);
    chk("timeout pins/busy", {tx_busy, ps2clk, ps2data}, 3'b011);
    repeat (40) @(negedge clk);
    chk("start while busy ignored", {tx_busy, ps2clk}, 2'b01);
    chk("timeout pulses", {32'(done_n - d0), 32'(err_n - e0)} == {32'd0, 32'd1}, 1);

    // reset after bit 3 of 0xF4 (bit 3 = 0, so data is held low)
    d0 = done_n; e0 = err_n;
    run_frame(8'hF4, 1'b1, 4, seen, ok);
    chk("mid-frame release", 32'(ok), 1);
    chk("mid-frame bits", 32'(seen[3:0]), 32'h4);
    chk("mid-frame busy/data", {tx_busy, ps2data}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    chk("reset mid-frame pins", {tx_busy, ps2clk, ps2data}, 3'b011);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("reset mid-frame no pulses", 32'(done_n - d0 + err_n - e0), 0);
    chk("reset mid-frame stays idle", {tx_busy, ps2clk, ps2data}, 3'b011);
    chk("done and err never together", 32'(both_n), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
